// File: rtl/cal_arbiter_rr_if.sv
// Requester-side bundle of the picture-memory port arbiter: request vector,
// mode select and the registered grant outputs.
interface cal_arbiter_rr_if #(
  parameter int N = 4
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]  req;
  logic          fixed_pri;
  logic [N-1:0]  grant;
  logic [IW-1:0] grant_id;
  logic          grant_valid;
  logic          preempt;

  modport master (
    output req, fixed_pri,
    input  grant, grant_id, grant_valid, preempt
  );

  modport slave (
    input  req, fixed_pri,
    output grant, grant_id, grant_valid, preempt
  );
endinterface

// File: rtl/cal_arbiter_rr.sv
// N-way round-robin / fixed-priority arbiter for the shared picture-memory port,
// with hold-time preemption after MAX_HOLD cycles when another requester waits.
module cal_arbiter_rr #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 16
) (
  input logic           clk,
  input logic           rst,
  cal_arbiter_rr_if.slave bus
);
  localparam int IW = $clog2(N);
  localparam int CW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state, state_nxt;
  logic [N-1:0]  grant_q, grant_nxt;
  logic [IW-1:0] id_q, id_nxt;
  logic [IW-1:0] rr_ptr, rr_nxt;
  logic          pre_q, pre_nxt;
  logic [CW-1:0] hold_q, hold_nxt;

  logic          owner_req, others, timeout, take;
  logic [N-1:0]  cand;
  logic [IW-1:0] rr_win, fx_win, win;
  logic          rr_hit;

  assign owner_req = (state == BUSY) && bus.req[id_q];
  assign others    = |(bus.req & ~grant_q);
  assign timeout   = (MAX_HOLD != 0) && owner_req && others && (hold_q == CW'(MAX_HOLD));
  // On preemption the owner's req is still high, so it must be masked out.
  assign cand      = timeout ? (bus.req & ~grant_q) : bus.req;

  always_comb begin
    rr_win = '0;
    rr_hit = 1'b0;
    for (int i = 1; i <= N; i++) begin
      int s;
      s = int'(rr_ptr) + i;
      if (s >= N) s = s - N;
      if (!rr_hit && cand[s[IW-1:0]]) begin
        rr_hit = 1'b1;
        rr_win = s[IW-1:0];
      end
    end
  end

  always_comb begin
    fx_win = '0;
    for (int i = N - 1; i >= 0; i--)
      if (cand[i]) fx_win = IW'(i);
  end

  assign win  = bus.fixed_pri ? fx_win : rr_win;
  assign take = (|cand) && ((state == IDLE) || !owner_req || timeout);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      grant_q <= '0;
      id_q    <= '0;
      rr_ptr  <= IW'(N - 1);
      pre_q   <= 1'b0;
      hold_q  <= '0;
    end else begin
      state   <= state_nxt;
      grant_q <= grant_nxt;
      id_q    <= id_nxt;
      rr_ptr  <= rr_nxt;
      pre_q   <= pre_nxt;
      hold_q  <= hold_nxt;
    end
  end

  // Next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (|bus.req) state_nxt = BUSY;
      BUSY: if (!owner_req && !others) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Registered output values
  always_comb begin
    grant_nxt = grant_q;
    id_nxt    = id_q;
    rr_nxt    = rr_ptr;
    pre_nxt   = 1'b0;
    hold_nxt  = hold_q;
    if (take) begin
      grant_nxt = {{(N-1){1'b0}}, 1'b1} << win;
      id_nxt    = win;
      rr_nxt    = win;
      hold_nxt  = CW'(1);
      pre_nxt   = timeout;
    end else if (state == BUSY && !owner_req) begin
      grant_nxt = '0;
      hold_nxt  = '0;
    end else if (state == BUSY && MAX_HOLD != 0 && hold_q < CW'(MAX_HOLD)) begin
      hold_nxt  = hold_q + CW'(1);
    end
  end

  assign bus.grant       = grant_q;
  assign bus.grant_id    = id_q;
  assign bus.grant_valid = |grant_q;
  assign bus.preempt     = pre_q;
endmodule

// File: tb/tb_cal_arbiter_rr.sv
// Directed-vector bench for cal_arbiter_rr at N=4, MAX_HOLD=4.
module tb_cal_arbiter_rr;
  localparam int N  = 4;
  localparam int MH = 4;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  cal_arbiter_rr_if #(.N(N)) bus ();

  cal_arbiter_rr #(.N(N), .MAX_HOLD(MH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_st(input string tag, input logic [3:0] g, input int id, input logic pre);
    chk({tag, ".grant"}, 32'(bus.grant), 32'(g));
    chk({tag, ".id"},    32'(bus.grant_id), 32'(id));
    chk({tag, ".valid"}, 32'(bus.grant_valid), 32'(|g));
    chk({tag, ".preempt"}, 32'(bus.preempt), 32'(pre));
  endtask

  initial begin
    rst = 1'b1;
    bus.req = '0;
    bus.fixed_pri = 1'b0;
    tick(); tick();
    rst = 1'b0;
    expect_st("reset", 4'b0000, 0, 1'b0);

    // Idle with no requests
    for (int k = 0; k < 5; k++) begin
      tick();
      expect_st("idle", 4'b0000, 0, 1'b0);
    end

    // Round-robin rotation under full load, 4 cycles each
    bus.req = 4'b1111;
    for (int k = 0; k < 20; k++) begin
      logic [3:0] g;
      int o;
      tick();
      o = (k / 4) % 4;
      g = 4'b0001 << o;
      expect_st("rr_rot", g, o, (k % 4 == 0) && (k > 0));
    end
    bus.req = '0;
    tick();
    expect_st("rr_release", 4'b0000, 0, 1'b0);

    // Release handover with no gap
    bus.req = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      tick();
      expect_st("ho_own1", 4'b0010, 1, 1'b0);
    end
    bus.req = 4'b0100;
    tick();
    expect_st("ho_to2", 4'b0100, 2, 1'b0);
    bus.req = '0;
    tick();
    expect_st("ho_idle", 4'b0000, 2, 1'b0);

    // Fixed priority with preemption excluding the owner
    bus.fixed_pri = 1'b1;
    bus.req = 4'b1110;
    for (int k = 0; k < 4; k++) begin
      tick();
      expect_st("fp_own1", 4'b0010, 1, 1'b0);
    end
    tick();
    expect_st("fp_pre2", 4'b0100, 2, 1'b1);
    bus.req = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      tick();
      expect_st("fp_own2", 4'b0100, 2, 1'b0);
    end
    tick();
    expect_st("fp_pre0", 4'b0001, 0, 1'b1);
    bus.req = '0;
    bus.fixed_pri = 1'b0;
    tick();
    expect_st("fp_idle", 4'b0000, 0, 1'b0);

    // Saturated counter, late contender
    bus.req = 4'b0001;
    for (int k = 0; k < 10; k++) begin
      tick();
      expect_st("sat_own0", 4'b0001, 0, 1'b0);
    end
    bus.req = 4'b1001;
    tick();
    expect_st("sat_pre3", 4'b1000, 3, 1'b1);
    tick();
    expect_st("sat_hold3", 4'b1000, 3, 1'b0);
    bus.req = '0;
    tick();
    expect_st("sat_idle", 4'b0000, 3, 1'b0);

    // Reset while granted
    bus.req = 4'b0100;
    tick();
    expect_st("rst_pre", 4'b0100, 2, 1'b0);
    bus.req = 4'b1111;
    tick();
    expect_st("rst_hold", 4'b0100, 2, 1'b0);
    rst = 1'b1;
    tick();
    expect_st("rst_drop", 4'b0000, 0, 1'b0);
    rst = 1'b0;
    tick();
    expect_st("rst_first", 4'b0001, 0, 1'b0);

    // Owner drops exactly at its timeout: plain release, no preempt
    tick(); tick(); tick();
    expect_st("to_own0", 4'b0001, 0, 1'b0);
    bus.req = 4'b1110;
    tick();
    expect_st("to_release", 4'b0010, 1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
